// File: rtl/temp_alarm_controller.sv
// Alarm policy stage behind the temperature abnormality detector: debounces typed flags,
// latches an alarm, drives heater/cooler, and clears only after sustained normal plus operator ack.
module temp_alarm_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLEAR_CYCLES    = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             sampleValid,
    input  logic             lowTempAbnormality,
    input  logic             highTempAbnormality,
    input  logic             alarmAck,
    output logic             heaterOn,
    output logic             coolerOn,
    output logic             alarmActive,
    output logic [1:0]       alarmType,
    output logic [CNT_W-1:0] lowEventCount,
    output logic [CNT_W-1:0] highEventCount,
    output logic             conflictError,
    output logic [2:0]       stateDbg
);

    // sampleValid is a valid-only strobe: the flags are consumed on every rising edge where it
    // is 1 and ignored otherwise; there is no back-pressure toward the detector.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOW_PEND   = 3'd1,
        S_HIGH_PEND  = 3'd2,
        S_LOW_ALARM  = 3'd3,
        S_HIGH_ALARM = 3'd4,
        S_RECOVER    = 3'd5
    } state_t;

    localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       CLR_LAST = 8'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             rec_high_q, rec_high_d;
    logic [3:0]       deb_q, deb_d;
    logic [7:0]       clr_q, clr_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             conflict_q, conflict_d;

    logic is_low, is_high, is_norm, is_conf;

    assign is_low  = sampleValid &  lowTempAbnormality & ~highTempAbnormality;
    assign is_high = sampleValid & ~lowTempAbnormality &  highTempAbnormality;
    assign is_norm = sampleValid & ~lowTempAbnormality & ~highTempAbnormality;
    assign is_conf = sampleValid &  lowTempAbnormality &  highTempAbnormality;

    always_comb begin
        state_d    = state_q;
        rec_high_d = rec_high_q;
        deb_d      = deb_q;
        clr_d      = clr_q;
        low_cnt_d  = low_cnt_q;
        high_cnt_d = high_cnt_q;
        conflict_d = is_conf;

        case (state_q)
            S_IDLE: begin
                if (is_low) begin
                    state_d = S_LOW_PEND;
                    deb_d   = 4'd1;
                end else if (is_high) begin
                    state_d = S_HIGH_PEND;
                    deb_d   = 4'd1;
                end
            end
            S_LOW_PEND: begin
                if (is_low) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = S_LOW_ALARM;
                        deb_d   = 4'd0;
                        clr_d   = 8'd0;
                        if (low_cnt_q != '1) low_cnt_d = low_cnt_q + CNT_ONE;
                    end else begin
                        deb_d = deb_q + 4'd1;
                    end
                end else if (is_norm) begin
                    state_d = S_IDLE;
                    deb_d   = 4'd0;
                end else if (is_high) begin
                    state_d = S_HIGH_PEND;
                    deb_d   = 4'd1;
                end
            end
            S_HIGH_PEND: begin
                if (is_high) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = S_HIGH_ALARM;
                        deb_d   = 4'd0;
                        clr_d   = 8'd0;
                        if (high_cnt_q != '1) high_cnt_d = high_cnt_q + CNT_ONE;
                    end else begin
                        deb_d = deb_q + 4'd1;
                    end
                end else if (is_norm) begin
                    state_d = S_IDLE;
                    deb_d   = 4'd0;
                end else if (is_low) begin
                    state_d = S_LOW_PEND;
                    deb_d   = 4'd1;
                end
            end
            S_LOW_ALARM: begin
                if (is_low) begin
                    clr_d = 8'd0;
                end else if (is_norm) begin
                    if (clr_q == CLR_LAST) begin
                        state_d    = S_RECOVER;
                        rec_high_d = 1'b0;
                        clr_d      = 8'd0;
                    end else begin
                        clr_d = clr_q + 8'd1;
                    end
                end else if (is_high) begin
                    state_d = S_HIGH_PEND;
                    deb_d   = 4'd1;
                    clr_d   = 8'd0;
                end
            end
            S_HIGH_ALARM: begin
                if (is_high) begin
                    clr_d = 8'd0;
                end else if (is_norm) begin
                    if (clr_q == CLR_LAST) begin
                        state_d    = S_RECOVER;
                        rec_high_d = 1'b1;
                        clr_d      = 8'd0;
                    end else begin
                        clr_d = clr_q + 8'd1;
                    end
                end else if (is_low) begin
                    state_d = S_LOW_PEND;
                    deb_d   = 4'd1;
                    clr_d   = 8'd0;
                end
            end
            S_RECOVER: begin
                // A fresh abnormal sample outranks the operator's acknowledge.
                if (is_low) begin
                    if (!rec_high_q) begin
                        state_d = S_LOW_ALARM;
                        clr_d   = 8'd0;
                    end else begin
                        state_d = S_LOW_PEND;
                        deb_d   = 4'd1;
                    end
                end else if (is_high) begin
                    if (rec_high_q) begin
                        state_d = S_HIGH_ALARM;
                        clr_d   = 8'd0;
                    end else begin
                        state_d = S_HIGH_PEND;
                        deb_d   = 4'd1;
                    end
                end else if (alarmAck && !is_conf) begin
                    state_d    = S_IDLE;
                    rec_high_d = 1'b0;
                    deb_d      = 4'd0;
                    clr_d      = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                deb_d   = 4'd0;
                clr_d   = 8'd0;
            end
        endcase

        // Conflicting flags carry no usable information; everything holds.
        if (is_conf) begin
            state_d    = state_q;
            rec_high_d = rec_high_q;
            deb_d      = deb_q;
            clr_d      = clr_q;
            low_cnt_d  = low_cnt_q;
            high_cnt_d = high_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= S_IDLE;
            rec_high_q <= 1'b0;
            deb_q      <= 4'd0;
            clr_q      <= 8'd0;
            low_cnt_q  <= '0;
            high_cnt_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_high_q <= rec_high_d;
            deb_q      <= deb_d;
            clr_q      <= clr_d;
            low_cnt_q  <= low_cnt_d;
            high_cnt_q <= high_cnt_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        heaterOn    = (state_q == S_LOW_ALARM);
        coolerOn    = (state_q == S_HIGH_ALARM);
        alarmActive = (state_q == S_LOW_ALARM) || (state_q == S_HIGH_ALARM) ||
                      (state_q == S_RECOVER);
        alarmType   = 2'b00;
        if (state_q == S_LOW_ALARM)  alarmType = 2'b01;
        if (state_q == S_HIGH_ALARM) alarmType = 2'b10;
        if (state_q == S_RECOVER)    alarmType = rec_high_q ? 2'b10 : 2'b01;
    end

    assign lowEventCount  = low_cnt_q;
    assign highEventCount = high_cnt_q;
    assign conflictError  = conflict_q;
    assign stateDbg       = state_q;

endmodule

// File: doc/temp_alarm_controller.md
Name: temp_alarm_controller

Overview:
Downstream stage of temperatureAbnormalityDetector: consumes its lowTempAbnormality/highTempAbnormality flags and decides on actions. Debounces flags over consecutive valid samples, latches a typed alarm, drives heater/cooler enables, and requires operator acknowledge plus a sustained return to normal before clearing. Keeps saturating per-type event counters for the status/display logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive valid abnormal samples of one type needed to raise an alarm (legal range 2..15)
CLEAR_CYCLES, 8, consecutive valid normal samples needed before an alarm may be acknowledged (legal range 2..255)
CNT_W, 8, width of each event counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rstN  input  1  synchronous active-low reset
sampleValid  input  1  abnormality flags valid this cycle (one sensor sample)
lowTempAbnormality  input  1  low-temperature flag from detector
highTempAbnormality  input  1  high-temperature flag from detector
alarmAck  input  1  operator acknowledge, level-sampled
heaterOn  output  1  heater enable
coolerOn  output  1  cooler enable
alarmActive  output  1  alarm latched (alarm or recovery state)
alarmType  output  2  00 none, 01 low, 10 high, 11 never driven
lowEventCount  output  CNT_W  number of low alarms raised, saturating
highEventCount  output  CNT_W  number of high alarms raised, saturating
conflictError  output  1  one-cycle pulse: both flags high on a valid sample

Behaviour:
- Reset: sync, active-low, sampled at rising clk; state IDLE, debounce/clear counters 0, all outputs 0, event counters 0. Reset mid-alarm drops everything to reset values the following cycle.
- Sample classes (only when sampleValid=1): LOW (low=1,high=0), HIGH (high=1,low=0), NORMAL (both 0), CONFLICT (both 1). sampleValid=0: state and all counters hold.
- CONFLICT: conflictError=1 in the cycle after the sample; otherwise ignored (state/counters hold).
- States: IDLE, LOW_PEND, HIGH_PEND, LOW_ALARM, HIGH_ALARM, RECOVER (remembers type).
- IDLE: LOW -> LOW_PEND, debCnt=1; HIGH -> HIGH_PEND, debCnt=1; NORMAL stay.
- LOW_PEND: LOW -> debCnt+1; on the sample that makes debCnt reach DEBOUNCE_CYCLES go LOW_ALARM, increment lowEventCount (saturate at all-ones), clrCnt=0. NORMAL -> IDLE, debCnt=0. HIGH -> HIGH_PEND, debCnt=1. HIGH_PEND symmetric.
- LOW_ALARM: LOW -> clrCnt=0; NORMAL -> clrCnt+1, reaching CLEAR_CYCLES goes RECOVER(low). HIGH -> HIGH_PEND, debCnt=1 (heater dropped immediately). alarmAck ignored. HIGH_ALARM symmetric.
- RECOVER: alarmAck=1 with no abnormal valid sample that cycle -> IDLE. Valid sample of the remembered type -> back to that ALARM state, clrCnt=0, no counter increment. Opposite type -> its PEND, debCnt=1. Abnormal sample beats simultaneous ack.
- Outputs Moore, decoded from the state register: visible the cycle after the transition edge. heaterOn=1 only in LOW_ALARM; coolerOn=1 only in HIGH_ALARM; never both. alarmActive=1 in *_ALARM and RECOVER. alarmType=01/10 in LOW/HIGH alarm states and RECOVER per remembered type, else 00.
- Debounce latency: alarm outputs assert exactly one cycle after the edge sampling the DEBOUNCE_CYCLES-th consecutive valid abnormal sample; gaps with sampleValid=0 do not break consecutiveness.

Test Plan:
- Reset then 4 consecutive valid LOW samples (DEBOUNCE_CYCLES=4) -> heaterOn=1, alarmType=01, alarmActive=1 one cycle after 4th sample; lowEventCount=1; 3 LOW then NORMAL -> stays idle, outputs 0.
- HIGH alarm, then 8 valid NORMAL samples with alarmAck=1 throughout -> ack ignored until RECOVER; coolerOn=0 after 8th; next cycle's ack -> IDLE, alarmType=00.
- LOW_ALARM, 5 NORMAL then 1 LOW then 8 NORMAL -> RECOVER only after the 8 consecutive NORMAL; heaterOn stays 1 until then.
- Valid sample with both flags high during LOW_PEND debCnt=2 -> conflictError pulses 1 cycle, debCnt still 2; 2 more LOW -> alarm.
- In RECOVER(high), assert alarmAck with a valid HIGH sample same cycle -> returns HIGH_ALARM, coolerOn=1, highEventCount unchanged.
- Force 256 low alarms with CNT_W=8 -> lowEventCount saturates at 255; assert rstN=0 mid-LOW_ALARM -> next cycle all outputs 0.
